life_controller: RTL and testbench

LIFE_CONTROLLER -- requirements
Module: life_controller

---
 rtl/life_controller.sv | 140 ++++++++++++++
 tb/tb_life_controller.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/life_controller.sv
// Control FSM for an 8x8 Game of Life engine: seeds, free-runs or single-steps the grid,
// and halts on still-life or extinction. The next-generation datapath lives outside this block.
module life_controller #(
   parameter int PERIOD = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [63:0] seed,
   input  logic        load,
   input  logic        start,
   input  logic        stop,
   input  logic        step,
   input  logic [63:0] grid_evolve,
   output logic [63:0] grid,
   output logic [15:0] gen_count,
   output logic        running,
   output logic        stable,
   output logic        extinct
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } state_t;

   localparam logic [15:0] LAST_TICK = 16'(PERIOD - 1);

   state_t      state_q, state_d;
   logic [63:0] grid_q, grid_d;
   logic [15:0] gen_count_q, gen_count_d;
   logic [15:0] tick_q, tick_d;
   logic        running_q, running_d;
   logic        stable_q, stable_d;
   logic        extinct_q, extinct_d;
   logic        do_update;

   // Next-state, update decision and flag logic; load overrides everything else
   always_comb begin
      state_d     = state_q;
      grid_d      = grid_q;
      gen_count_d = gen_count_q;
      tick_d      = tick_q;
      stable_d    = stable_q;
      extinct_d   = extinct_q;
      do_update   = 1'b0;

      if (load) begin
         state_d     = IDLE;
         grid_d      = seed;
         gen_count_d = 16'd0;
         tick_d      = 16'd0;
         stable_d    = 1'b0;
         extinct_d   = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               // stop outranks start/step even though it has nothing to do here
               if (stop) begin
                  state_d = IDLE;
               end else if (start) begin
                  state_d = RUN;
                  tick_d  = 16'd0;
               end else if (step) begin
                  do_update = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end
            RUN: begin
               if (stop) begin
                  state_d = IDLE;
                  tick_d  = 16'd0;
               end else if (tick_q == LAST_TICK) begin
                  do_update = 1'b1;
                  tick_d    = 16'd0;
               end else begin
                  tick_d = tick_q + 16'd1;
               end
            end
            HALT: begin
               state_d = HALT;
            end
            default: begin
               state_d = IDLE;
               tick_d  = 16'd0;
            end
         endcase

         // Still-life check precedes extinction so an empty grid that stays empty is only stable
         if (do_update) begin
            if (grid_evolve == grid_q) begin
               stable_d = 1'b1;
               state_d  = HALT;
            end else begin
               grid_d      = grid_evolve;
               gen_count_d = (gen_count_q == 16'hFFFF) ? 16'hFFFF : gen_count_q + 16'd1;
               if ((grid_evolve == 64'd0) && (grid_q != 64'd0)) begin
                  extinct_d = 1'b1;
                  state_d   = HALT;
               end else begin
                  extinct_d = extinct_q;
               end
            end
         end else begin
            grid_d = grid_d;
         end
      end

      running_d = (state_d == RUN);
   end

   // State and output registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         grid_q      <= 64'd0;
         gen_count_q <= 16'd0;
         tick_q      <= 16'd0;
         running_q   <= 1'b0;
         stable_q    <= 1'b0;
         extinct_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         grid_q      <= grid_d;
         gen_count_q <= gen_count_d;
         tick_q      <= tick_d;
         running_q   <= running_d;
         stable_q    <= stable_d;
         extinct_q   <= extinct_d;
      end
   end

   assign grid      = grid_q;
   assign gen_count = gen_count_q;
   assign running   = running_q;
   assign stable    = stable_q;
   assign extinct   = extinct_q;

endmodule

// File: tb/tb_life_controller.sv
// Directed bench for life_controller: a Game of Life next-generation model closes the loop
// on grid, a vector table covers per-cycle control, and hand sequences cover reset and saturation.
module tb_life_controller;

   logic        clk;
   logic        reset;
   logic [63:0] seed;
   logic        load, start, stop, step;
   logic [63:0] grid_evolve;
   logic [63:0] grid;
   logic [15:0] gen_count;
   logic        running, stable, extinct;

   int n_compared;
   int n_mismatched;

   life_controller #(.PERIOD(4)) dut (
      .clk         (clk),
      .reset       (reset),
      .seed        (seed),
      .load        (load),
      .start       (start),
      .stop        (stop),
      .step        (step),
      .grid_evolve (grid_evolve),
      .grid        (grid),
      .gen_count   (gen_count),
      .running     (running),
      .stable      (stable),
      .extinct     (extinct)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference datapath: cells outside the 8x8 board are dead; row r col c is bit 63-8r-c
   function automatic logic [63:0] life_next(input logic [63:0] g);
      logic [63:0] n;
      int cnt;
      n = 64'd0;
      for (int r = 0; r < 8; r++) begin
         for (int c = 0; c < 8; c++) begin
            cnt = 0;
            for (int dr = -1; dr <= 1; dr++) begin
               for (int dc = -1; dc <= 1; dc++) begin
                  if ((dr != 0 || dc != 0) && (r + dr >= 0) && (r + dr < 8) &&
                      (c + dc >= 0) && (c + dc < 8)) begin
                     if (g[63 - 8 * (r + dr) - (c + dc)]) cnt++;
                  end
               end
            end
            n[63 - 8 * r - c] = (cnt == 3) || (cnt == 2 && g[63 - 8 * r - c]);
         end
      end
      return n;
   endfunction

   always_comb grid_evolve = life_next(grid);

   typedef struct {
      logic        ld, st, sp, stp;
      logic [63:0] sd;
      logic [63:0] e_grid;
      logic [15:0] e_gen;
      logic        e_run, e_stable, e_extinct;
   } vec_t;

   localparam logic [63:0] BLINK_V = 64'h0000_0808_0800_0000;
   localparam logic [63:0] BLINK_H = 64'h0000_001C_0000_0000;
   localparam logic [63:0] BLOCK   = 64'h0000_0018_1800_0000;
   localparam logic [63:0] LONE    = 64'h0000_0008_0000_0000;

   vec_t vecs [32];

   function automatic vec_t mk(input logic ld, input logic st, input logic sp, input logic stp,
                               input logic [63:0] sd, input logic [63:0] eg, input logic [15:0] en,
                               input logic er, input logic es, input logic ee);
      vec_t v;
      v.ld = ld; v.st = st; v.sp = sp; v.stp = stp; v.sd = sd;
      v.e_grid = eg; v.e_gen = en; v.e_run = er; v.e_stable = es; v.e_extinct = ee;
      return v;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_compared++;
      if (act !== exp) begin
         n_mismatched++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_all(input string tag, input logic [63:0] eg, input logic [15:0] en,
                            input logic er, input logic es, input logic ee);
      check({tag, ".grid"}, grid, eg);
      check({tag, ".gen_count"}, 64'(gen_count), 64'(en));
      check({tag, ".running"}, 64'(running), 64'(er));
      check({tag, ".stable"}, 64'(stable), 64'(es));
      check({tag, ".extinct"}, 64'(extinct), 64'(ee));
   endtask

   task automatic pulse(input logic ld, input logic st, input logic sp, input logic stp,
                        input logic [63:0] sd);
      load = ld; start = st; stop = sp; step = stp; seed = sd;
      @(posedge clk);
      @(negedge clk);
      load = 1'b0; start = 1'b0; stop = 1'b0; step = 1'b0;
   endtask

   initial begin
      n_compared   = 0;
      n_mismatched = 0;
      //                ld    st    sp    stp   seed     exp grid  gen    run   stab  ext
      vecs[0]  = mk(1'b1, 1'b0, 1'b0, 1'b0, BLINK_V, BLINK_V, 16'd0, 1'b0, 1'b0, 1'b0);
      vecs[1]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 64'd0,   BLINK_V, 16'd0, 1'b1, 1'b0, 1'b0);
      vecs[2]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 64'd0,   BLINK_V, 16'd0, 1'b1, 1'b0, 1'b0);
      vecs[3]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 64'd0,   BLINK_V, 16'd0, 1'b1, 1'b0, 1'b0);
      vecs[4]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 64'd0,   BLINK_V, 16'd0, 1'b1, 1'b0, 1'b0);
      vecs[5]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 64'd0,   BLINK_H, 16'd1, 1'b1, 1'b0, 1'b0);
      vecs[6]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 64'd0,   BLINK_H, 16'd1, 1'b1, 1'b0, 1'b0);
      vecs[7]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 64'd0,   BLINK_H, 16'd1, 1'b1, 1'b0, 1'b0);
      vecs[8]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 64'd0,   BLINK_H, 16'd1, 1'b1, 1'b0, 1'b0);
      vecs[9]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 64'd0,   BLINK_V, 16'd2, 1'b1, 1'b0, 1'b0);
      vecs[10] = mk(1'b1, 1'b1, 1'b0, 1'b0, BLINK_V, BLINK_V, 16'd0, 1'b0, 1'b0, 1'b0);
      vecs[11] = mk(1'b0, 1'b0, 1'b0, 1'b1, 64'd0,   BLINK_H, 16'd1, 1'b0, 1'b0, 1'b0);
      vecs[12] = mk(1'b0, 1'b0, 1'b1, 1'b1, 64'd0,   BLINK_H, 16'd1, 1'b0, 1'b0, 1'b0);
      vecs[13] = mk(1'b0, 1'b1, 1'b0, 1'b1, 64'd0,   BLINK_H, 16'd1, 1'b1, 1'b0, 1'b0);
      vecs[14] = mk(1'b0, 1'b0, 1'b0, 1'b1, 64'd0,   BLINK_H, 16'd1, 1'b1, 1'b0, 1'b0);
      vecs[15] = mk(1'b0, 1'b0, 1'b0, 1'b0, 64'd0,   BLINK_H, 16'd1, 1'b1, 1'b0, 1'b0);
      vecs[16] = mk(1'b0, 1'b0, 1'b0, 1'b0, 64'd0,   BLINK_H, 16'd1, 1'b1, 1'b0, 1'b0);
      vecs[17] = mk(1'b0, 1'b0, 1'b1, 1'b0, 64'd0,   BLINK_H, 16'd1, 1'b0, 1'b0, 1'b0);
      vecs[18] = mk(1'b0, 1'b0, 1'b0, 1'b1, 64'd0,   BLINK_V, 16'd2, 1'b0, 1'b0, 1'b0);
      vecs[19] = mk(1'b1, 1'b0, 1'b0, 1'b0, BLOCK,   BLOCK,   16'd0, 1'b0, 1'b0, 1'b0);
      vecs[20] = mk(1'b0, 1'b0, 1'b0, 1'b1, 64'd0,   BLOCK,   16'd0, 1'b0, 1'b1, 1'b0);
      vecs[21] = mk(1'b0, 1'b1, 1'b0, 1'b0, 64'd0,   BLOCK,   16'd0, 1'b0, 1'b1, 1'b0);
      vecs[22] = mk(1'b0, 1'b0, 1'b0, 1'b1, 64'd0,   BLOCK,   16'd0, 1'b0, 1'b1, 1'b0);
      vecs[23] = mk(1'b1, 1'b0, 1'b0, 1'b0, LONE,    LONE,    16'd0, 1'b0, 1'b0, 1'b0);
      vecs[24] = mk(1'b0, 1'b1, 1'b0, 1'b0, 64'd0,   LONE,    16'd0, 1'b1, 1'b0, 1'b0);
      vecs[25] = mk(1'b0, 1'b0, 1'b0, 1'b0, 64'd0,   LONE,    16'd0, 1'b1, 1'b0, 1'b0);
      vecs[26] = mk(1'b0, 1'b0, 1'b0, 1'b0, 64'd0,   LONE,    16'd0, 1'b1, 1'b0, 1'b0);
      vecs[27] = mk(1'b0, 1'b0, 1'b0, 1'b0, 64'd0,   LONE,    16'd0, 1'b1, 1'b0, 1'b0);
      vecs[28] = mk(1'b0, 1'b0, 1'b0, 1'b0, 64'd0,   64'd0,   16'd1, 1'b0, 1'b0, 1'b1);
      vecs[29] = mk(1'b0, 1'b1, 1'b0, 1'b0, 64'd0,   64'd0,   16'd1, 1'b0, 1'b0, 1'b1);
      vecs[30] = mk(1'b1, 1'b0, 1'b0, 1'b0, 64'd0,   64'd0,   16'd0, 1'b0, 1'b0, 1'b0);
      vecs[31] = mk(1'b0, 1'b0, 1'b0, 1'b1, 64'd0,   64'd0,   16'd0, 1'b0, 1'b1, 1'b0);

      reset = 1'b1;
      seed = 64'd0; load = 1'b0; start = 1'b0; stop = 1'b0; step = 1'b0;
      repeat (2) @(negedge clk);
      check_all("reset", 64'd0, 16'd0, 1'b0, 1'b0, 1'b0);
      reset = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 32; i++) begin
         load = vecs[i].ld; start = vecs[i].st; stop = vecs[i].sp; step = vecs[i].stp;
         seed = vecs[i].sd;
         @(posedge clk);
         @(negedge clk);
         check_all($sformatf("vec%0d", i), vecs[i].e_grid, vecs[i].e_gen,
                   vecs[i].e_run, vecs[i].e_stable, vecs[i].e_extinct);
      end
      load = 1'b0; start = 1'b0; stop = 1'b0; step = 1'b0;

      // Reset mid-RUN must clear outputs before the next rising edge
      pulse(1'b1, 1'b0, 1'b0, 1'b0, BLINK_V);
      pulse(1'b0, 1'b1, 1'b0, 1'b0, 64'd0);
      repeat (5) @(negedge clk);
      check_all("pre_reset", BLINK_H, 16'd1, 1'b1, 1'b0, 1'b0);
      #2 reset = 1'b1;
      #1 check_all("async_reset", 64'd0, 16'd0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      repeat (5) @(negedge clk);
      check_all("after_reset_idle", 64'd0, 16'd0, 1'b0, 1'b0, 1'b0);

      // Saturation: preload the counter through a backdoor, then step the blinker twice
      pulse(1'b1, 1'b0, 1'b0, 1'b0, BLINK_V);
      force dut.gen_count_q = 16'hFFFE;
      @(posedge clk);
      @(negedge clk);
      release dut.gen_count_q;
      #1 check("sat.preload", 64'(gen_count), 64'hFFFE);
      pulse(1'b0, 1'b0, 1'b0, 1'b1, 64'd0);
      check_all("sat.step1", BLINK_H, 16'hFFFF, 1'b0, 1'b0, 1'b0);
      pulse(1'b0, 1'b0, 1'b0, 1'b1, 64'd0);
      check_all("sat.step2", BLINK_V, 16'hFFFF, 1'b0, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
